// File: rtl/trig_record_buffer.sv
// Trigger record buffer: captures {pattern, trigger number, timestamp} per accepted
// trigger, queues records in a FIFO and streams each as three 32-bit words.
module trig_record_buffer #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 48
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   trig_accept,
    input  logic [7:0]             trig_pattern,
    input  logic                   run_start,
    output logic [31:0]            m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy_out,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            drop_count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int RW       = 8 + 16 + TS_WIDTH;
    localparam int BUSY_INT = DEPTH - 2;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] BUSY_LVL = BUSY_INT[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } stateT;

    stateT                state;
    logic [TS_WIDTH-1:0]  tsReg;
    logic [15:0]          tnumReg;
    logic [TS_WIDTH-1:0]  tsNow;
    logic [15:0]          tnumNow;
    logic [15:0]          dropNow;
    logic [15:0]          dropNext;
    logic                 wrEn;
    logic                 dropEv;
    logic                 popEn;
    logic [AW:0]          countNext;
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    logic [RW-1:0]        mem [DEPTH];
    logic [RW-1:0]        popRec;
    logic [TS_WIDTH-1:0]  holdTs;

    // Header word of a record laid out as {pattern, tnum, ts}
    function automatic logic [31:0] w0Word(input logic [RW-1:0] rec);
        return {8'hA5, rec[RW-1 -: 8], rec[TS_WIDTH +: 16]};
    endfunction

    // run_start makes the counters read as zero in the cycle it is asserted
    always_comb begin
        tsNow    = {TS_WIDTH{1'b0}};
        tnumNow  = 16'h0000;
        dropNow  = 16'h0000;
        dropNext = 16'h0000;
        if (run_start) begin
            tsNow   = {TS_WIDTH{1'b0}};
            tnumNow = 16'h0000;
            dropNow = 16'h0000;
        end else begin
            tsNow   = tsReg;
            tnumNow = tnumReg;
            dropNow = drop_count;
        end
        wrEn   = trig_accept && (fifo_count < FULL_LVL);
        dropEv = trig_accept && (fifo_count == FULL_LVL);
        if (dropEv && (dropNow != 16'hFFFF)) begin
            dropNext = dropNow + 16'h0001;
        end else begin
            dropNext = dropNow;
        end
    end

    // Pop into the holding register when leaving IDLE or finishing W2 with data waiting
    always_comb begin
        popRec = mem[rdPtr];
        popEn  = 1'b0;
        case (state)
            IDLE:    popEn = (fifo_count != {(AW+1){1'b0}});
            W2:      popEn = m_tready && (fifo_count != {(AW+1){1'b0}});
            default: popEn = 1'b0;
        endcase
        case ({wrEn, popEn})
            2'b10:   countNext = fifo_count + (AW+1)'(1);
            2'b01:   countNext = fifo_count - (AW+1)'(1);
            default: countNext = fifo_count;
        endcase
    end

    // Timestamp, trigger number and drop counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tsReg      <= {TS_WIDTH{1'b0}};
            tnumReg    <= 16'h0000;
            drop_count <= 16'h0000;
        end else begin
            tsReg      <= tsNow + TS_WIDTH'(1);
            tnumReg    <= tnumNow + {15'h0000, trig_accept};
            drop_count <= dropNext;
        end
    end

    // Record storage
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrPtr] <= {trig_pattern, tnumNow, tsNow};
        end
    end

    // FIFO pointers, occupancy and almost-full flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr      <= {AW{1'b0}};
            rdPtr      <= {AW{1'b0}};
            fifo_count <= {(AW+1){1'b0}};
            busy_out   <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            fifo_count <= countNext;
            busy_out   <= (countNext >= BUSY_LVL);
        end
    end

    // Serializer FSM with registered stream outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            m_tdata  <= 32'h0000_0000;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            holdTs   <= {TS_WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (popEn) begin
                        holdTs   <= popRec[TS_WIDTH-1:0];
                        m_tdata  <= w0Word(popRec);
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        state    <= W0;
                    end
                end
                W0: begin
                    if (m_tready) begin
                        m_tdata <= holdTs[31:0];
                        state   <= W1;
                    end
                end
                W1: begin
                    if (m_tready) begin
                        m_tdata <= {16'h0000, holdTs[47:32]};
                        m_tlast <= 1'b1;
                        state   <= W2;
                    end
                end
                W2: begin
                    if (m_tready) begin
                        if (popEn) begin
                            holdTs  <= popRec[TS_WIDTH-1:0];
                            m_tdata <= w0Word(popRec);
                            m_tlast <= 1'b0;
                            state   <= W0;
                        end else begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_record_buffer.sv
// Directed bench for trig_record_buffer: a per-cycle vector table for the single
// trigger case, then hand sequences for backpressure, overflow, run_start and reset.
module tb_trig_record_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        trig_accept;
    logic [7:0]  trig_pattern;
    logic        run_start;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy_out;
    logic [4:0]  fifo_count;
    logic [15:0] drop_count;

    int nTests = 0;
    int nFail  = 0;
    logic [31:0] words[$];
    logic        lasts[$];

    typedef struct {
        logic        ta;
        logic [7:0]  pat;
        logic        rs;
        logic        rdy;
        logic        eValid;
        logic [31:0] eData;
        logic        eLast;
        logic [4:0]  eCount;
    } vecT;

    vecT vecs[16];

    trig_record_buffer #(.DEPTH(16), .TS_WIDTH(48)) dut (
        .clock        (clock),
        .reset        (reset),
        .trig_accept  (trig_accept),
        .trig_pattern (trig_pattern),
        .run_start    (run_start),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy_out     (busy_out),
        .fifo_count   (fifo_count),
        .drop_count   (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic endCycle();
        @(posedge clock);
        #1;
    endtask

    // Leaves the caller at the negedge of the first cycle with m_tvalid high
    task automatic waitValid(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (!m_tvalid && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(m_tvalid), 32'd1);
    endtask

    task automatic collect(input string name, input int n, input int budget);
        int cyc;
        cyc = 0;
        words.delete();
        lasts.delete();
        while (words.size() < n && cyc < budget) begin
            @(negedge clock);
            if (m_tvalid && m_tready) begin
                words.push_back(m_tdata);
                lasts.push_back(m_tlast);
            end
            endCycle();
            cyc++;
        end
        check(name, 32'(words.size()), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int badLast;
        reset        = 1'b1;
        trig_accept  = 1'b0;
        trig_pattern = 8'h00;
        run_start    = 1'b0;
        m_tready     = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_tdata",  m_tdata, 32'h0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast",  32'(m_tlast), 32'd0);
        check("rst_busy",   32'(busy_out), 32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        check("rst_drop",   32'(drop_count), 32'd0);
        reset = 1'b0;

        // Single trigger: run_start at cycle 0, pattern 0x05 at cycle 10
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{ta: 1'b0, pat: 8'h00, rs: 1'b0, rdy: 1'b1, eValid: 1'b0,
                        eData: 32'h0, eLast: 1'b0, eCount: 5'd0};
        end
        vecs[0].rs      = 1'b1;
        vecs[10].ta     = 1'b1;
        vecs[10].pat    = 8'h05;
        vecs[11].eCount = 5'd1;
        vecs[12].eValid = 1'b1;  vecs[12].eData = 32'hA505_0000;
        vecs[13].eValid = 1'b1;  vecs[13].eData = 32'h0000_000A;
        vecs[14].eValid = 1'b1;  vecs[14].eData = 32'h0000_0000;  vecs[14].eLast = 1'b1;

        for (int i = 0; i < 16; i++) begin
            trig_accept  = vecs[i].ta;
            trig_pattern = vecs[i].pat;
            run_start    = vecs[i].rs;
            m_tready     = vecs[i].rdy;
            @(negedge clock);
            check($sformatf("vec%0d_valid", i), 32'(m_tvalid), 32'(vecs[i].eValid));
            check($sformatf("vec%0d_last", i), 32'(m_tlast), 32'(vecs[i].eLast));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].eCount));
            if (vecs[i].eValid) begin
                check($sformatf("vec%0d_data", i), m_tdata, vecs[i].eData);
            end
            endCycle();
        end
        trig_accept = 1'b0;
        run_start   = 1'b0;

        // Backpressure: record ts=2, tnum=0, held for 5 stalled cycles
        m_tready  = 1'b0;
        run_start = 1'b1;
        endCycle();
        run_start = 1'b0;
        endCycle();
        trig_accept  = 1'b1;
        trig_pattern = 8'h3C;
        endCycle();
        trig_accept = 1'b0;
        waitValid("bp_wait", 10);
        endCycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d_valid", k), 32'(m_tvalid), 32'd1);
            check($sformatf("bp_hold%0d_data", k), m_tdata, 32'hA53C_0000);
            endCycle();
        end
        m_tready = 1'b1;
        collect("bp_words", 3, 10);
        if (words.size() == 3) begin
            check("bp_w0", words[0], 32'hA53C_0000);
            check("bp_w1", words[1], 32'h0000_0002);
            check("bp_w2", words[2], 32'h0000_0000);
            check("bp_last", 32'({lasts[0], lasts[1], lasts[2]}), 32'd1);
        end
        @(negedge clock);
        check("bp_idle_after", 32'(m_tvalid), 32'd0);
        endCycle();

        // Overflow: serializer already holds one record, so the FIFO sees all 20 triggers
        m_tready     = 1'b0;
        trig_accept  = 1'b1;
        trig_pattern = 8'hAA;
        endCycle();
        trig_accept = 1'b0;
        waitValid("ovf_pre_wait", 10);
        endCycle();
        for (int i = 0; i < 20; i++) begin
            trig_accept  = 1'b1;
            trig_pattern = 8'(i);
            run_start    = (i == 0);
            @(negedge clock);
            if (i == 13) begin
                check("ovf_count13", 32'(fifo_count), 32'd13);
                check("ovf_busy13", 32'(busy_out), 32'd0);
            end
            if (i == 14) begin
                check("ovf_count14", 32'(fifo_count), 32'd14);
                check("ovf_busy14", 32'(busy_out), 32'd1);
            end
            endCycle();
        end
        trig_accept = 1'b0;
        run_start   = 1'b0;
        @(negedge clock);
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_drop", 32'(drop_count), 32'd4);
        check("ovf_busy", 32'(busy_out), 32'd1);
        endCycle();
        m_tready = 1'b1;
        collect("ovf_words", 51, 120);
        if (words.size() == 51) begin
            check("ovf_first_rec", words[0], 32'hA5AA_0001);
            for (int k = 0; k < 16; k++) begin
                check($sformatf("ovf_rec%0d", k), words[3 + 3*k], {8'hA5, 8'(k), 16'(k)});
            end
            badLast = 0;
            for (int k = 0; k < 51; k++) begin
                if (lasts[k] !== ((k % 3) == 2)) badLast++;
            end
            check("ovf_lasts", 32'(badLast), 32'd0);
        end
        @(negedge clock);
        check("ovf_drained_count", 32'(fifo_count), 32'd0);
        check("ovf_drained_busy", 32'(busy_out), 32'd0);
        check("ovf_drop_kept", 32'(drop_count), 32'd4);
        endCycle();

        // Coincident start after ts has run past 1000
        run_start = 1'b1;
        endCycle();
        run_start = 1'b0;
        repeat (1000) endCycle();
        m_tready     = 1'b0;
        trig_accept  = 1'b1;
        run_start    = 1'b1;
        trig_pattern = 8'h11;
        endCycle();
        trig_accept = 1'b0;
        run_start   = 1'b0;
        endCycle();
        endCycle();
        trig_accept  = 1'b1;
        trig_pattern = 8'h22;
        endCycle();
        trig_accept = 1'b0;
        m_tready    = 1'b1;
        collect("cs_words", 6, 30);
        if (words.size() == 6) begin
            check("cs_r0_w0", words[0], 32'hA511_0000);
            check("cs_r0_w1", words[1], 32'h0000_0000);
            check("cs_r1_w0", words[3], 32'hA522_0001);
            check("cs_r1_w1", words[4], 32'h0000_0003);
            check("cs_r1_w2", words[5], 32'h0000_0000);
        end

        // Reset while in W1 with 3 records queued
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trig_accept  = 1'b1;
            run_start    = (i == 0);
            trig_pattern = 8'h01;
            endCycle();
        end
        trig_accept = 1'b0;
        run_start   = 1'b0;
        waitValid("rm_wait", 10);
        check("rm_w0", m_tdata, 32'hA501_0000);
        endCycle();
        m_tready = 1'b1;
        endCycle();
        m_tready = 1'b0;
        @(negedge clock);
        check("rm_in_w1_data", m_tdata, 32'h0000_0000);
        check("rm_in_w1_valid", 32'(m_tvalid), 32'd1);
        check("rm_queued", 32'(fifo_count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("rm_tvalid", 32'(m_tvalid), 32'd0);
        check("rm_tlast", 32'(m_tlast), 32'd0);
        check("rm_tdata", m_tdata, 32'h0);
        check("rm_busy", 32'(busy_out), 32'd0);
        check("rm_count", 32'(fifo_count), 32'd0);
        check("rm_drop", 32'(drop_count), 32'd0);
        endCycle();
        reset    = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("rm_quiet%0d", k), 32'({m_tvalid, fifo_count}), 32'd0);
            endCycle();
        end
        trig_accept  = 1'b1;
        trig_pattern = 8'h77;
        endCycle();
        trig_accept = 1'b0;
        collect("rm_new_words", 3, 10);
        if (words.size() == 3) begin
            check("rm_new_w0", words[0], 32'hA577_0000);
            check("rm_new_last", 32'(lasts[2]), 32'd1);
        end

        // Back-to-back: 4 triggers give 12 consecutive valid words
        for (int i = 0; i < 16; i++) begin
            trig_accept  = (i < 4);
            run_start    = (i == 0);
            trig_pattern = 8'h40 + 8'(i);
            m_tready     = 1'b1;
            @(negedge clock);
            check($sformatf("b2b%0d_valid", i), 32'(m_tvalid), 32'(i >= 2 && i <= 13));
            check($sformatf("b2b%0d_last", i), 32'(m_tlast),
                  32'(i == 4 || i == 7 || i == 10 || i == 13));
            if (i >= 2 && i <= 13 && ((i - 2) % 3) == 0) begin
                check($sformatf("b2b%0d_w0", i), m_tdata,
                      {8'hA5, 8'h40 + 8'((i - 2) / 3), 16'((i - 2) / 3)});
            end
            endCycle();
        end
        trig_accept = 1'b0;
        run_start   = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/trig_record_buffer.md
# trig_record_buffer

Downstream stage of the external-trigger block. It consumes the one-cycle accepted-trigger pulse and the raw 8-bit trigger pattern, and captures a record for each trigger: trigger number, pattern and 48-bit timestamp. Records are buffered in a DEPTH-entry FIFO and serialized as three 32-bit words on a valid/ready stream toward the DAQ readout. When the FIFO nears full, the block asserts `busy_out`, which feeds the trigger block's busy input so that triggers are vetoed before records are lost.

## Interface
- `DEPTH`, 16: number of FIFO records; power of two, minimum 4.
- `TS_WIDTH`, 48: timestamp width; fixed at 48 for this record format.

- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `trig_accept`  in  1  one-cycle pulse per accepted trigger.
- `trig_pattern`  in  8  trigger-input pattern, sampled when `trig_accept` is high.
- `run_start`  in  1  one-cycle pulse; clears timestamp, trigger number and drop counter.
- `m_tdata`  out  32  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  high on word 2 of each record.
- `busy_out`  out  1  registered almost-full flag.
- `fifo_count`  out  $clog2(DEPTH)+1  number of records currently stored.
- `drop_count`  out  16  number of records dropped because the FIFO was full; saturates.

## Operation
- **Timestamp counter `ts`** (48 bit)
  - Free-running; increments every cycle and wraps at 2^48-1 to 0.
  - `run_start` loads 0.
- **Trigger number `tnum`** (16 bit)
  - Increments on every `trig_accept`, including triggers whose record is dropped; wraps from 0xFFFF to 0.
  - `run_start` loads 0.
- **Record capture**
  - On `trig_accept`, the record {pattern, tnum, ts} uses the register values in that cycle.
  - If `run_start` is high in the same cycle, the record is captured with ts=0 and tnum=0. The registers then hold ts=1, tnum=1 on the following cycle.
- **FIFO write**
  - A write occurs when `trig_accept` is high and the registered `fifo_count` < DEPTH.
  - If `fifo_count` == DEPTH, the record is discarded and `drop_count` increments, saturating at 0xFFFF. This holds even if a pop occurs in the same cycle.
  - `run_start` clears `drop_count`. If a drop coincides with `run_start`, the result is `drop_count` = 1.
- **FIFO storage**: memory is indexed by pointers that wrap modulo DEPTH. The FIFO is not flushed by `run_start`.
- **Serializer FSM**: states IDLE, W0, W1, W2.
  - IDLE → W0 when `fifo_count` > 0. The record is popped into an output holding register on this transition.
  - W0 → W1 → W2 each advance on `m_tvalid` && `m_tready`.
  - W2 on handshake → W0 if `fifo_count` > 0, popping the next record so there is no bubble. Otherwise W2 → IDLE.
  - `m_tvalid` = 1 in W0, W1 and W2.
  - `m_tdata` and `m_tvalid` stay stable while `m_tvalid` && !`m_tready`.
- **Word format**
  - W0 = {8'hA5, pattern[7:0], tnum[15:0]}.
  - W1 = ts[31:0].
  - W2 = {16'h0000, ts[47:32]}, with `m_tlast` = 1.
- **`fifo_count`**: +1 on a write, −1 on a pop, unchanged on a simultaneous write and pop.
- **`busy_out`**: registered form of (next `fifo_count` >= DEPTH-2).
- **Reset mid-operation**
  - Returns the FSM to IDLE and empties the FIFO.
  - Clears `ts`, `tnum` and `drop_count`.
  - Deasserts `m_tvalid`, `m_tlast` and `busy_out` asynchronously.
  - A partially sent record is abandoned.

## Timing
- **Reset values**: `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `busy_out`=0, `fifo_count`=0, `drop_count`=0.
- **Write latency**: `trig_accept` in cycle N writes the FIFO at the end of cycle N, so `fifo_count` increments in cycle N+1.
- **Pop latency, empty FIFO and FSM in IDLE**:
  - The pop occurs in cycle N+1.
  - `m_tvalid` and W0 are first visible in cycle N+2.
  - `fifo_count` returns to 0 in cycle N+2.
- **Throughput**: one word per cycle with `m_tready` held high. Back-to-back records produce no idle cycle between W2 and the next W0.
- **`busy_out` latency**: follows `fifo_count` with the same one-cycle latency.
- **Trigger spacing**: `trig_accept` may be high on consecutive cycles; every cycle is a separate trigger.

## Test plan
- **Single trigger**: reset, `run_start` at cycle 0, `trig_accept` with pattern 0x05 at cycle 10, `m_tready`=1.
  - Required stream: 0xA5050000, 0x0000000A, 0x00000000, with `m_tlast` on the third word.
  - `m_tvalid` first goes high at cycle 12.
- **Backpressure**: with `m_tready`=0 for 5 cycles while valid, word W0 is held unchanged. After `m_tready` rises, the three words appear in order with no duplicates.
- **Overflow**: DEPTH=16, `m_tready`=0, 20 triggers on consecutive cycles.
  - Required: `fifo_count`=16, `drop_count`=4, `busy_out` high from the 14th write.
  - After draining, tnum values read out are 0..15.
- **Coincident start**: `trig_accept` and `run_start` in the same cycle after ts has reached 1000.
  - The record carries ts=0 and tnum=0.
  - The next trigger, 3 cycles later, carries ts=3 and tnum=1.
- **Reset mid-record**: assert `reset` while in W1 with 3 records queued.
  - All outputs are 0 immediately.
  - After release, no stream activity occurs until a new `trig_accept`.
- **Back-to-back records**: 4 triggers with `m_tready`=1 produce 12 consecutive valid cycles, and `m_tlast` is high on words 3, 6, 9 and 12.
